// File: rtl/mtr_pkg.sv
// Shared definitions for the motor duty shaper and the PWM stage it feeds.
// Holds the PWM word width, the mid-scale duty, the mode enum and the slew helper.
package mtr_pkg;

  localparam int PWM_W = 11;
  localparam logic [PWM_W-1:0] DUTY_MID = 11'h400;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    TRACK    = 2'd1,
    BRAKE    = 2'd2
  } shaper_state_e;

  // Moves cur toward target by at most step; snaps onto target once within reach.
  function automatic logic [PWM_W-1:0] slew_toward(
    input logic [PWM_W-1:0] cur,
    input logic [PWM_W-1:0] target,
    input logic [PWM_W-1:0] step
  );
    logic signed [PWM_W:0] diff;
    logic signed [PWM_W:0] step_s;
    logic [PWM_W-1:0]      nxt;
    diff   = $signed({1'b0, target}) - $signed({1'b0, cur});
    step_s = $signed({1'b0, step});
    if (diff > step_s) begin
      nxt = cur + step;
    end else if (diff < -step_s) begin
      nxt = cur - step;
    end else begin
      nxt = target;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pwm_period_tmr.sv
// Free-running PWM period counter; flags the last cycle of each period.
// Kept separate so the PWM stage can share the exact same period alignment.
module pwm_period_tmr
  import mtr_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  output logic [PWM_W-1:0] cnt,
  output logic             boundary
);

  logic [PWM_W-1:0] cnt_q;
  logic [PWM_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt      = cnt_q;
  assign boundary = &cnt_q;

endmodule

// File: rtl/mtr_duty_shaper.sv
// Turns a signed speed command into a slew-limited PWM duty word.
// Duty only moves on the period wrap so the PWM comparator never sees a mid-period change.
module mtr_duty_shaper
  import mtr_pkg::*;
#(
  parameter int unsigned SLEW_STEP  = 16,
  parameter int unsigned BRAKE_STEP = 128,
  parameter int unsigned DUTY_MIN   = 32,
  parameter int unsigned DUTY_MAX   = 2015
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic signed [11:0]  spd_cmd,
  input  logic                cmd_vld,
  input  logic                enable,
  input  logic                brake,
  output logic [PWM_W-1:0]    duty,
  output logic                upd,
  output logic                at_tgt
);

  localparam logic [PWM_W-1:0]  SLEW_W  = PWM_W'(SLEW_STEP);
  localparam logic [PWM_W-1:0]  BRAKE_W = PWM_W'(BRAKE_STEP);
  localparam logic [PWM_W-1:0]  MIN_W   = PWM_W'(DUTY_MIN);
  localparam logic [PWM_W-1:0]  MAX_W   = PWM_W'(DUTY_MAX);
  localparam logic signed [11:0] MIN_S  = 12'(DUTY_MIN);
  localparam logic signed [11:0] MAX_S  = 12'(DUTY_MAX);

  shaper_state_e    state_q, state_d;
  logic [PWM_W-1:0] tgt_q, tgt_d;
  logic [PWM_W-1:0] duty_q, duty_d;
  logic             upd_q, upd_d;
  logic             at_tgt_q, at_tgt_d;

  logic [PWM_W-1:0] period_cnt;
  logic             boundary;
  logic             unused_period_cnt;

  logic signed [11:0] tgt_sum;
  logic [PWM_W-1:0]   tgt_clamped;
  logic [PWM_W-1:0]   active_tgt;

  pwm_period_tmr u_tmr (
    .clk      (clk),
    .rst_n    (rst_n),
    .cnt      (period_cnt),
    .boundary (boundary)
  );

  // The counter value itself is only consumed by the PWM stage.
  assign unused_period_cnt = ^period_cnt;

  // Mid-scale plus half the command always lands in 0..2047, so the sum cannot overflow.
  always_comb begin
    tgt_sum     = $signed({1'b0, DUTY_MID}) + (spd_cmd >>> 1);
    tgt_clamped = tgt_sum[PWM_W-1:0];
    if (tgt_sum < MIN_S) begin
      tgt_clamped = MIN_W;
    end else if (tgt_sum > MAX_S) begin
      tgt_clamped = MAX_W;
    end
  end

  always_comb begin
    state_d = TRACK;
    if (!enable) begin
      state_d = DISABLED;
    end else if (brake) begin
      state_d = BRAKE;
    end

    tgt_d = tgt_q;
    if (cmd_vld) begin
      tgt_d = tgt_clamped;
    end

    // Stepping uses the state and target held before the boundary cycle.
    duty_d = duty_q;
    if (boundary) begin
      unique case (state_q)
        DISABLED: duty_d = DUTY_MID;
        TRACK:    duty_d = slew_toward(duty_q, tgt_q, SLEW_W);
        BRAKE:    duty_d = slew_toward(duty_q, DUTY_MID, BRAKE_W);
        default:  duty_d = DUTY_MID;
      endcase
    end

    upd_d = boundary && (duty_d != duty_q);

    active_tgt = (state_d == TRACK) ? tgt_d : DUTY_MID;
    at_tgt_d   = (duty_d == active_tgt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= DISABLED;
      tgt_q    <= DUTY_MID;
      duty_q   <= DUTY_MID;
      upd_q    <= 1'b0;
      at_tgt_q <= 1'b1;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      duty_q   <= duty_d;
      upd_q    <= upd_d;
      at_tgt_q <= at_tgt_d;
    end
  end

  assign duty   = duty_q;
  assign upd    = upd_q;
  assign at_tgt = at_tgt_q;

endmodule

// File: tb/tb_mtr_duty_shaper.sv
// Scoreboard bench for mtr_duty_shaper; larger step sizes keep each ramp to a few periods.
// Expected duty/at_tgt pairs are queued by the stimulus and popped by the monitor on upd.
module tb_mtr_duty_shaper;

  localparam int SLEW  = 256;
  localparam int BRK   = 512;
  localparam int PER   = 2048;

  typedef struct {
    int duty;
    int at;
  } exp_t;

  logic               clk;
  logic               rst_n;
  logic signed [11:0] spd_cmd;
  logic               cmd_vld;
  logic               enable;
  logic               brake;
  logic [10:0]        duty;
  logic               upd;
  logic               at_tgt;

  logic [10:0] tb_cnt;
  exp_t        sb[$];
  int          n_checks;
  int          n_fail;
  bit          mon_en;
  int          prev_duty;

  mtr_duty_shaper #(
    .SLEW_STEP  (SLEW),
    .BRAKE_STEP (BRK),
    .DUTY_MIN   (32),
    .DUTY_MAX   (2015)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .spd_cmd (spd_cmd),
    .cmd_vld (cmd_vld),
    .enable  (enable),
    .brake   (brake),
    .duty    (duty),
    .upd     (upd),
    .at_tgt  (at_tgt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bench-side period phase, used to place stimulus and to check update alignment.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cnt <= '0;
    else        tb_cnt <= tb_cnt + 11'd1;
  end

  task automatic check_output(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_cnt(input int v);
    for (int i = 0; i < 2 * PER && int'(tb_cnt) != v; i++) @(negedge clk);
  endtask

  task automatic apply_stimulus(input int spd);
    spd_cmd = 12'(spd);
    cmd_vld = 1'b1;
    @(negedge clk);
    cmd_vld = 1'b0;
  endtask

  task automatic push(input int d, input int a);
    exp_t e;
    e.duty = d;
    e.at   = a;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string name, input int bound);
    for (int i = 0; i < bound && sb.size() != 0; i++) @(negedge clk);
    check_output(name, sb.size(), 0);
    sb.delete();
  endtask

  // Monitor: every duty change must sit at phase 0 with upd, and match the queue head.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (int'(duty) != prev_duty) begin
        check_output("upd_align_phase", int'(tb_cnt), 0);
        check_output("upd_on_change", int'(upd), 1);
        prev_duty = int'(duty);
      end
      if (upd) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_upd: got duty %0d, expected no update", duty);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_output("sb_duty", int'(duty), e.duty);
          check_output("sb_at_tgt", int'(at_tgt), e.at);
        end
      end
    end else if (!rst_n) begin
      prev_duty = 1024;
    end
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    mon_en   = 1'b0;
    prev_duty = 1024;
    rst_n    = 1'b1;
    enable   = 1'b0;
    brake    = 1'b0;
    cmd_vld  = 1'b0;
    spd_cmd  = '0;

    #13 rst_n = 1'b0;
    #1;
    check_output("reset_duty", int'(duty), 1024);
    check_output("reset_upd", int'(upd), 0);
    check_output("reset_at_tgt", int'(at_tgt), 1);
    tick(3 * PER);
    check_output("reset_hold_duty", int'(duty), 1024);
    check_output("reset_hold_upd", int'(upd), 0);

    $display("[TB] forward ramp to clamped maximum");
    rst_n  = 1'b1;
    mon_en = 1'b1;
    enable = 1'b1;
    tick(2);
    apply_stimulus(2047);
    push(1280, 0); push(1536, 0); push(1792, 0); push(2015, 1);
    wait_drain("fwd_drain", 5 * PER);
    check_output("fwd_at_tgt", int'(at_tgt), 1);

    $display("[TB] brake mid-period");
    wait_cnt(100);
    brake = 1'b1;
    push(1503, 0); push(1024, 1);
    wait_drain("brake_drain", 3 * PER);
    tick(PER + 10);
    check_output("brake_idle_duty", int'(duty), 1024);
    check_output("brake_idle_at_tgt", int'(at_tgt), 1);

    $display("[TB] brake release resumes tracking");
    brake = 1'b0;
    push(1280, 0);
    wait_drain("release_drain", 2 * PER);

    $display("[TB] disable mid-period");
    wait_cnt(1000);
    enable = 1'b0;
    tick(500);
    check_output("disable_hold_duty", int'(duty), 1280);
    push(1024, 1);
    wait_drain("disable_drain", 2 * PER);

    $display("[TB] reverse ramp to clamped minimum");
    enable = 1'b1;
    apply_stimulus(-2048);
    push(768, 0); push(512, 0); push(256, 0); push(32, 1);
    wait_drain("rev_drain", 5 * PER);
    check_output("rev_at_tgt", int'(at_tgt), 1);

    $display("[TB] command in the boundary cycle");
    wait_cnt(2047);
    apply_stimulus(0);
    tick(10);
    check_output("collide_old_tgt_duty", int'(duty), 32);
    push(288, 0);
    wait_drain("collide_drain", 2 * PER + 10);

    $display("[TB] reset mid-ramp");
    wait_cnt(500);
    #2 rst_n = 1'b0;
    #1;
    check_output("midramp_reset_duty", int'(duty), 1024);
    check_output("midramp_reset_upd", int'(upd), 0);
    check_output("midramp_reset_at_tgt", int'(at_tgt), 1);
    tick(3);
    rst_n = 1'b1;
    apply_stimulus(2047);
    push(1280, 0);
    wait_drain("restart_drain", 2 * PER + 10);

    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mtr_duty_shaper.md
# mtr_duty_shaper

Converts a signed 12-bit motor speed command into the 11-bit duty word consumed by the 11-bit PWM generator. Sits directly upstream of the PWM stage, one instance per motor. Applies clamping, slew-rate limiting and braking. Updates duty only on PWM period boundaries, so the PWM comparator never sees a mid-period duty change.

## Interface
Parameters:
- SLEW_STEP, 16: maximum duty change per PWM period in TRACK.
- BRAKE_STEP, 128: maximum duty change per PWM period in BRAKE.
- DUTY_MIN, 32: lower duty clamp (keeps bootstrap capacitors charged).
- DUTY_MAX, 2015: upper duty clamp.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- spd_cmd  in  12  signed speed command, −2048..2047.
- cmd_vld  in  1  one-cycle strobe; captures spd_cmd.
- enable  in  1  level; low forces zero torque.
- brake  in  1  level; ramps duty to mid-scale at BRAKE_STEP.
- duty  out  11  registered duty word to the PWM stage.
- upd  out  1  one-cycle pulse when duty changed at a boundary.
- at_tgt  out  1  registered; duty equals the active target.

## Operation
- **Target.** On cmd_vld, compute tgt = clamp(DUTY_MID + (spd_cmd >>> 1), DUTY_MIN, DUTY_MAX) and register it.
  - Arithmetic is 12-bit signed; the sum is always in 0..2047, so no overflow.
  - tgt resets to DUTY_MID (1024).
- **Period timer.** A free-running 11-bit counter, reset to 0 and incremented every clk, stays cycle-aligned with the PWM stage counter. A boundary occurs when it holds 2047.
- **State machine.** States are DISABLED, TRACK and BRAKE; reset state is DISABLED. State is re-evaluated every cycle with priority !enable > brake > track.
  - DISABLED: at each boundary, duty := DUTY_MID immediately, with no slew.
  - TRACK: at each boundary, diff = tgt − duty (12-bit signed). If |diff| ≤ SLEW_STEP then duty := tgt, else duty := duty ± SLEW_STEP.
  - BRAKE: same step rule with BRAKE_STEP, toward DUTY_MID.
  - Release of brake with enable high → TRACK, continuing to slew from the current duty.
- **Active target.** tgt in TRACK; DUTY_MID in DISABLED or BRAKE. at_tgt = (duty == active target).
- **Between boundaries**, duty holds regardless of cmd_vld, enable or brake changes.

## Timing
- Reset values: duty = 1024, upd = 0, at_tgt = 1, timer = 0, tgt = 1024, state = DISABLED.
- The boundary step uses the tgt and state registered before the boundary cycle. A cmd_vld or mode change in the boundary cycle itself takes effect at the next boundary, 2048 cycles later.
- duty changes on the edge where the timer wraps 2047→0, so the PWM stage compares against the new duty starting at its cnt = 0.
- Latency from cmd_vld to first duty step: 1 to 2048 cycles.
- upd is asserted in the cycle the new duty is visible (timer = 0). It is not asserted when the step is zero.
- Reset mid-ramp returns all registers to reset values at once; ramping restarts from 1024.

## Structure
- Shared package mtr_pkg holds:
  - the state enum typedef (DISABLED/TRACK/BRAKE);
  - DUTY_MID = 11'h400;
  - PWM_W = 11.
- One sub-module, pwm_period_tmr: the 11-bit free-running counter with a boundary output. The PWM stage may reuse it later.
- Slew stepping and target computation stay in the top module.

## Test plan
- **Reset:** assert rst_n low mid-cycle → duty = 1024, upd = 0, at_tgt = 1 asynchronously. Hold for 3 boundaries → duty stays 1024.
- **Forward ramp:** enable = 1, cmd_vld with spd_cmd = 2047 → tgt = 2015.
  - First boundary: duty = 1040.
  - Then +16 per boundary; duty = 2015 and at_tgt = 1 after 62 boundaries, with a last step of 15.
- **Reverse clamp:** spd_cmd = −2048 from duty = 1024 → tgt = 32 (clamped from 0). Duty falls by 16 per period and reaches 32 after 62 boundaries.
- **Brake mid-ramp:** duty = 1504, assert brake → duty 1376, 1248, 1120, 1024 over 4 boundaries. Then upd stays 0 and at_tgt = 1.
- **Disable and boundary collision:**
  - Drop enable mid-period at duty = 1600 → duty holds until the boundary, then becomes 1024 in one step.
  - cmd_vld in the boundary cycle → the old tgt is used; the new tgt is used one period later.
- **Alignment check:** with a PWM stage instance on duty, the PWM high time per period equals duty cycles, with no partial or extra periods across duty updates.
